// File: rtl/branch_resolve_pkg.sv
// Shared definitions for the branch resolution slice: branch op codes,
// resolution FSM states and a saturating increment helper.
package branch_resolve_pkg;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_BEQ  = 4'd1,
    OP_BNE  = 4'd2,
    OP_BLT  = 4'd3,
    OP_BGE  = 4'd4,
    OP_BLTU = 4'd5,
    OP_BGEU = 4'd6,
    OP_B    = 4'd7,
    OP_BL   = 4'd8,
    OP_JIRL = 4'd9
  } br_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } br_state_e;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/branch_resolve_cmp.sv
// branch_cmp: combinational branch direction evaluation (op, rj, rd -> taken).
module branch_cmp
  import branch_resolve_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] rj_i,
  input  logic [31:0] rd_i,
  output logic        taken_o
);

  // Direction per op; unconditional jumps always taken, non-branches never.
  always_comb begin
    taken_o = 1'b0;
    case (op_i)
      OP_BEQ:  taken_o = (rj_i == rd_i);
      OP_BNE:  taken_o = (rj_i != rd_i);
      OP_BLT:  taken_o = ($signed(rj_i) <  $signed(rd_i));
      OP_BGE:  taken_o = ($signed(rj_i) >= $signed(rd_i));
      OP_BLTU: taken_o = (rj_i <  rd_i);
      OP_BGEU: taken_o = (rj_i >= rd_i);
      OP_B, OP_BL, OP_JIRL: taken_o = 1'b1;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// branch_resolve: EX-stage branch resolution. Resolves direction/target,
// flags mispredicts, holds a redirect to fetch until accepted, and pulses a
// one-cycle BTB training update.
// Optional feature macro: BRANCH_STAT_EN (enables saturating statistics counters).
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int PC_INDEX_WIDTH = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        ex_valid,
  input  logic        ex_flush,
  input  logic [31:0] ex_pc,
  input  logic [3:0]  ex_br_op,
  input  logic [31:0] ex_rj,
  input  logic [31:0] ex_rd,
  input  logic [31:0] ex_imm,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_pc,
  input  logic        if0_allowin,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [31:0] fact_pc,
  output logic [31:0] fact_tpc,
  output logic        fact_taken,
  output logic        predict_dir_fail,
  output logic        predict_add_fail,
  output logic [31:0] stat_total,
  output logic [31:0] stat_dir_fail,
  output logic [31:0] stat_add_fail
);

  br_state_e   state_q, state_d;
  logic        taken;
  logic        is_br;
  logic        accept;
  logic        dir_fail;
  logic        add_fail;
  logic [31:0] target;
  logic [31:0] seq_pc;
  logic [31:0] redirect_pc_q, fact_pc_q, fact_tpc_q;
  logic        fact_taken_q, dir_fail_q, add_fail_q;

  // Index width only mirrors the BTB instantiation; nothing here depends on it.
  logic [PC_INDEX_WIDTH-1:0] unused_pc_index;
  assign unused_pc_index = ex_pc[PC_INDEX_WIDTH+1:2];

  branch_cmp u_cmp (
    .op_i    (ex_br_op),
    .rj_i    (ex_rj),
    .rd_i    (ex_rd),
    .taken_o (taken)
  );

  // Resolution datapath and acceptance qualification.
  always_comb begin
    is_br    = (ex_br_op != OP_NONE);
    seq_pc   = ex_pc + 32'd4;
    target   = (ex_br_op == OP_JIRL) ? ex_rj + ex_imm : ex_pc + ex_imm;
    accept   = ex_valid && (state_q == IDLE) && !ex_flush;
    dir_fail = (ex_pred_taken != taken);
    add_fail = taken && ex_pred_taken && (ex_pred_pc != target);
  end

  // Next-state: enter HOLD on a mispredict, leave when fetch accepts; flush wins.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept && (dir_fail || add_fail)) state_d = HOLD;
      HOLD: if (if0_allowin) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (ex_flush) state_d = IDLE;
  end

  // State register plus registered training update and redirect target.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= IDLE;
      redirect_pc_q <= '0;
      fact_pc_q     <= '0;
      fact_tpc_q    <= '0;
      fact_taken_q  <= 1'b0;
      dir_fail_q    <= 1'b0;
      add_fail_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      fact_taken_q <= accept && taken;
      dir_fail_q   <= accept && dir_fail;
      add_fail_q   <= accept && add_fail;
      if (accept) begin
        fact_pc_q  <= ex_pc;
        fact_tpc_q <= is_br ? target : seq_pc;
      end
      if (accept && (dir_fail || add_fail)) begin
        redirect_pc_q <= taken ? target : seq_pc;
      end
    end
  end

  assign redirect_valid   = (state_q == HOLD);
  assign redirect_pc      = redirect_pc_q;
  assign fact_pc          = fact_pc_q;
  assign fact_tpc         = fact_tpc_q;
  assign fact_taken       = fact_taken_q;
  assign predict_dir_fail = dir_fail_q;
  assign predict_add_fail = add_fail_q;

`ifdef BRANCH_STAT_EN
  logic [31:0] stat_total_q, stat_dir_fail_q, stat_add_fail_q;

  // Saturating counters over accepted real branches.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      stat_total_q    <= '0;
      stat_dir_fail_q <= '0;
      stat_add_fail_q <= '0;
    end else if (accept && is_br) begin
      stat_total_q <= sat_inc(stat_total_q);
      if (dir_fail) stat_dir_fail_q <= sat_inc(stat_dir_fail_q);
      if (add_fail) stat_add_fail_q <= sat_inc(stat_add_fail_q);
    end
  end

  assign stat_total    = stat_total_q;
  assign stat_dir_fail = stat_dir_fail_q;
  assign stat_add_fail = stat_add_fail_q;
`else
  assign stat_total    = '0;
  assign stat_dir_fail = '0;
  assign stat_add_fail = '0;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed scenarios followed by
// randomized traffic, all compared against a behavioural reference model.
module tb_branch_resolve;

  logic        clk = 1'b0;
  logic        rstn;
  logic        ex_valid, ex_flush;
  logic [31:0] ex_pc, ex_rj, ex_rd, ex_imm, ex_pred_pc;
  logic [3:0]  ex_br_op;
  logic        ex_pred_taken, if0_allowin;
  logic        redirect_valid, fact_taken, predict_dir_fail, predict_add_fail;
  logic [31:0] redirect_pc, fact_pc, fact_tpc;
  logic [31:0] stat_total, stat_dir_fail, stat_add_fail;

  always #5 clk = ~clk;

  branch_resolve #(.PC_INDEX_WIDTH(8)) dut (
    .clk              (clk),
    .rstn             (rstn),
    .ex_valid         (ex_valid),
    .ex_flush         (ex_flush),
    .ex_pc            (ex_pc),
    .ex_br_op         (ex_br_op),
    .ex_rj            (ex_rj),
    .ex_rd            (ex_rd),
    .ex_imm           (ex_imm),
    .ex_pred_taken    (ex_pred_taken),
    .ex_pred_pc       (ex_pred_pc),
    .if0_allowin      (if0_allowin),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .fact_pc          (fact_pc),
    .fact_tpc         (fact_tpc),
    .fact_taken       (fact_taken),
    .predict_dir_fail (predict_dir_fail),
    .predict_add_fail (predict_add_fail),
    .stat_total       (stat_total),
    .stat_dir_fail    (stat_dir_fail),
    .stat_add_fail    (stat_add_fail)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Reference model state
  bit          m_pending;
  logic [31:0] m_rpc, m_fpc, m_ftpc;
  bit          m_ft, m_df, m_af;
  logic [31:0] m_tot, m_dfc, m_afc;

  function automatic bit ref_taken(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd1: return a == b;
      4'd2: return a != b;
      4'd3: return $signed(a) <  $signed(b);
      4'd4: return $signed(a) >= $signed(b);
      4'd5: return a <  b;
      4'd6: return a >= b;
      4'd7, 4'd8, 4'd9: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_target(input logic [3:0] op, input logic [31:0] pc,
                                             input logic [31:0] rj, input logic [31:0] imm);
    return (op == 4'd9) ? rj + imm : pc + imm;
  endfunction

  function automatic logic [31:0] inc_sat(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 1;
  endfunction

  task automatic model_step();
    bit          acc, tk, df, af;
    logic [31:0] tgt;
    if (!rstn) begin
      m_pending = 0; m_rpc = 0; m_fpc = 0; m_ftpc = 0;
      m_ft = 0; m_df = 0; m_af = 0; m_tot = 0; m_dfc = 0; m_afc = 0;
      return;
    end
    acc = ex_valid && !m_pending && !ex_flush;
    tk  = ref_taken(ex_br_op, ex_rj, ex_rd);
    tgt = ref_target(ex_br_op, ex_pc, ex_rj, ex_imm);
    df  = (ex_pred_taken != tk);
    af  = tk && ex_pred_taken && (ex_pred_pc != tgt);
    m_ft = acc && tk;
    m_df = acc && df;
    m_af = acc && af;
    if (acc) begin
      m_fpc  = ex_pc;
      m_ftpc = (ex_br_op == 4'd0) ? ex_pc + 4 : tgt;
      if (ex_br_op != 4'd0) begin
        m_tot = inc_sat(m_tot);
        if (df) m_dfc = inc_sat(m_dfc);
        if (af) m_afc = inc_sat(m_afc);
      end
    end
    if (ex_flush) m_pending = 0;
    else if (m_pending) begin
      if (if0_allowin) m_pending = 0;
    end else if (acc && (df || af)) begin
      m_pending = 1;
      m_rpc = tk ? tgt : ex_pc + 4;
    end
  endtask

  task automatic check_all();
    check("redirect_valid", {31'b0, redirect_valid}, {31'b0, m_pending});
    check("redirect_pc", redirect_pc, m_rpc);
    check("fact_pc", fact_pc, m_fpc);
    check("fact_tpc", fact_tpc, m_ftpc);
    check("fact_taken", {31'b0, fact_taken}, {31'b0, m_ft});
    check("dir_fail", {31'b0, predict_dir_fail}, {31'b0, m_df});
    check("add_fail", {31'b0, predict_add_fail}, {31'b0, m_af});
`ifdef BRANCH_STAT_EN
    check("stat_total", stat_total, m_tot);
    check("stat_dir_fail", stat_dir_fail, m_dfc);
    check("stat_add_fail", stat_add_fail, m_afc);
`else
    check("stat_total", stat_total, 32'd0);
    check("stat_dir_fail", stat_dir_fail, 32'd0);
    check("stat_add_fail", stat_add_fail, 32'd0);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic drv(input logic [3:0] op, input logic [31:0] pc, input logic [31:0] rj,
                     input logic [31:0] rd, input logic [31:0] imm, input logic pt,
                     input logic [31:0] ppc, input logic v, input logic fl, input logic al);
    ex_br_op = op; ex_pc = pc; ex_rj = rj; ex_rd = rd; ex_imm = imm;
    ex_pred_taken = pt; ex_pred_pc = ppc; ex_valid = v; ex_flush = fl; if0_allowin = al;
  endtask

  task automatic idle(input logic al);
    drv(4'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, al);
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] pc, rj, rd, imm, ppc;
    logic        pt;

    rstn = 1'b0;
    idle(1'b1);
    step();
    step();
    rstn = 1'b1;
    idle(1'b1);
    step();

    // beq taken, correctly predicted
    drv(4'd1, 32'h1c000010, 32'd5, 32'd5, 32'h20, 1'b1, 32'h1c000030, 1'b1, 1'b0, 1'b1);
    step();
    check("beq_taken", {31'b0, fact_taken}, 32'd1);
    check("beq_tpc", fact_tpc, 32'h1c000030);
    check("beq_noredirect", {31'b0, redirect_valid}, 32'd0);
    idle(1'b1);
    step();
    check("beq_pulse_end", {31'b0, fact_taken}, 32'd0);

    // bne with equal operands predicted taken, fetch stalls 3 cycles
    drv(4'd2, 32'h1c000100, 32'd7, 32'd7, 32'h40, 1'b1, 32'h1c000140, 1'b1, 1'b0, 1'b0);
    step();
    check("bne_dirfail", {31'b0, predict_dir_fail}, 32'd1);
    check("bne_rpc", redirect_pc, 32'h1c000104);
    idle(1'b0);
    step();
    step();
    check("bne_held", {31'b0, redirect_valid}, 32'd1);
    idle(1'b1);
    step();
    check("bne_released", {31'b0, redirect_valid}, 32'd0);

    // jirl with wrong predicted address
    drv(4'd9, 32'h1c000200, 32'h1c001000, 32'd0, 32'd4, 1'b1, 32'h1c002000, 1'b1, 1'b0, 1'b1);
    step();
    check("jirl_addfail", {31'b0, predict_add_fail}, 32'd1);
    check("jirl_rpc", redirect_pc, 32'h1c001004);
    check("jirl_taken", {31'b0, fact_taken}, 32'd1);
    idle(1'b1);
    step();

    // signed vs unsigned compare on the same operands
    drv(4'd3, 32'h1c000300, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b1, 32'h1c000310, 1'b1, 1'b0, 1'b1);
    step();
    check("blt_taken", {31'b0, fact_taken}, 32'd1);
    drv(4'd5, 32'h1c000400, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b0, 32'h1c000404, 1'b1, 1'b0, 1'b1);
    step();
    check("bltu_taken", {31'b0, fact_taken}, 32'd0);
    idle(1'b1);
    step();

    // mispredict, wrong-path valid in HOLD, then flush
    drv(4'd2, 32'h1c000500, 32'd3, 32'd3, 32'h8, 1'b1, 32'h1c000508, 1'b1, 1'b0, 1'b0);
    step();
    drv(4'd7, 32'h1c000504, 32'd0, 32'd0, 32'h80, 1'b1, 32'h1c000584, 1'b1, 1'b0, 1'b0);
    step();
    check("hold_no_fact", {31'b0, fact_taken}, 32'd0);
    drv(4'd7, 32'h1c000508, 32'd0, 32'd0, 32'h80, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    step();
    check("flush_drop", {31'b0, redirect_valid}, 32'd0);
    idle(1'b1);
    step();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      op  = 4'($urandom_range(0, 9));
      pc  = {$urandom_range(32'h0700_0000, 32'h0700_0fff), 2'b00};
      rj  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
      rd  = ($urandom_range(0, 2) == 0) ? rj : (($urandom_range(0, 1) == 0) ? $urandom : rj + 1);
      imm = {{16{1'b0}}, 16'($urandom)} - 32'h8000;
      pt  = 1'($urandom_range(0, 1));
      ppc = ($urandom_range(0, 1) == 0) ? ref_target(op, pc, rj, imm) : $urandom;
      drv(op, pc, rj, rd, imm, pt, ppc, 1'($urandom_range(0, 4) != 0),
          1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 3) != 0));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
